// File: rtl/rfid6c_pkg.sv
// Shared types and constants for the 6C (EPC Gen2) tag digital core.
// State encoding, QueryAdjust UpDn codes, Q ceiling, slot wrap value.
package rfid6c_pkg;

  typedef enum logic [1:0] {
    READY        = 2'd0,
    ARBITRATE    = 2'd1,
    REPLY        = 2'd2,
    ACKNOWLEDGED = 2'd3
  } slot_st_e;

  localparam logic [1:0] UPDN_NC = 2'b00;
  localparam logic [1:0] UPDN_DN = 2'b01;
  localparam logic [1:0] UPDN_UP = 2'b11;

  localparam int Q_MAX = 15;

  localparam logic [14:0] SLOT_WRAP = 15'h7FFF;

endpackage

// File: rtl/gen2_slot_ctrl_if.sv
// Command/response bundle between the command decoder and the slot controller.
// master: decoder side drives pulses and fields; slave: slot controller drives state and requests.
interface gen2_slot_ctrl_if
  import rfid6c_pkg::*;
#(
  parameter int Q_W    = 4,
  parameter int SLOT_W = 15
);

  logic [15:0]       rns;
  logic              cmd_select;
  logic              cmd_query;
  logic [Q_W-1:0]    query_q;
  logic              cmd_query_adj;
  logic [1:0]        updn;
  logic              cmd_query_rep;
  logic              cmd_ack;
  logic [15:0]       ack_rn;
  logic              cmd_nak;

  slot_st_e          state;
  logic [Q_W-1:0]    q_cur;
  logic [SLOT_W-1:0] slot_cnt;
  logic [15:0]       rn16;
  logic              reply_req;
  logic              epc_req;

  modport master (
    output rns, cmd_select, cmd_query, query_q,
    output cmd_query_adj, updn, cmd_query_rep,
    output cmd_ack, ack_rn, cmd_nak,
    input  state, q_cur, slot_cnt, rn16,
    input  reply_req, epc_req
  );

  modport slave (
    input  rns, cmd_select, cmd_query, query_q,
    input  cmd_query_adj, updn, cmd_query_rep,
    input  cmd_ack, ack_rn, cmd_nak,
    output state, q_cur, slot_cnt, rn16,
    output reply_req, epc_req
  );

endinterface

// File: rtl/gen2_slot_mask.sv
// Saturating Q up/down and Q -> (1<<Q)-1 slot mask, purely combinational.
// Ports: q_base, updn in; q_new (adjusted Q), mask (of q_new) out.
module gen2_slot_mask
  import rfid6c_pkg::*;
#(
  parameter int Q_W    = 4,
  parameter int SLOT_W = 15
) (
  input  logic [Q_W-1:0]    q_base,
  input  logic [1:0]        updn,
  output logic [Q_W-1:0]    q_new,
  output logic [SLOT_W-1:0] mask
);

  logic [SLOT_W:0] one_sh;

  always_comb begin
    q_new = q_base;
    unique case (updn)
      UPDN_UP: if (q_base != Q_W'(Q_MAX)) q_new = q_base + Q_W'(1);
      UPDN_DN: if (q_base != '0) q_new = q_base - Q_W'(1);
      default: ;
    endcase
  end

  // Q == SLOT_W shifts the one out of the low bits, so the
  // subtraction wraps to all ones.
  assign one_sh = (SLOT_W+1)'(1) << q_new;
  assign mask   = one_sh[SLOT_W-1:0] - SLOT_W'(1);

endmodule

// File: rtl/gen2_slot_ctrl.sv
// Gen2 inventory slot controller: Q/slot handling, RN16 latch, ACK handle check.
// Ports: clk_1_92m, rst_n (sync, active-low), bus (slave: commands in, state/requests out).
module gen2_slot_ctrl
  import rfid6c_pkg::*;
#(
  parameter int Q_W    = 4,
  parameter int SLOT_W = 15
) (
  input  logic         clk_1_92m,
  input  logic         rst_n,
  gen2_slot_ctrl_if.slave bus
);

  slot_st_e          st_q, st_n;
  logic [Q_W-1:0]    q_q, q_n;
  logic [SLOT_W-1:0] slot_q, slot_n;
  logic [15:0]       rn_q, rn_n;
  logic              rep_q, rep_n;
  logic              epc_q, epc_n;

  logic [5:0]        raw, one;
  logic [Q_W-1:0]    q_base, q_new;
  logic [1:0]        ud;
  logic [SLOT_W-1:0] mask, slot_ld, slot_dec;
  logic              load;

  // Bit 0 is highest priority; isolating the lowest set bit keeps
  // exactly one command active per cycle.
  assign raw = {bus.cmd_nak, bus.cmd_ack, bus.cmd_query_rep,
                bus.cmd_query_adj, bus.cmd_query, bus.cmd_select};
  assign one = raw & ~(raw - 6'd1);

  // Query forces UpDn to "unchanged" so the mask tracks query_q.
  assign q_base = one[1] ? bus.query_q : q_q;
  assign ud     = one[1] ? UPDN_NC : bus.updn;

  gen2_slot_mask #(
    .Q_W   (Q_W),
    .SLOT_W(SLOT_W)
  ) u_mask (
    .q_base(q_base),
    .updn  (ud),
    .q_new (q_new),
    .mask  (mask)
  );

  assign slot_ld  = bus.rns[SLOT_W-1:0] & mask;
  assign slot_dec = slot_q - SLOT_W'(1);

  always_comb begin
    st_n   = st_q;
    q_n    = q_q;
    slot_n = slot_q;
    rn_n   = rn_q;
    rep_n  = 1'b0;
    epc_n  = 1'b0;
    load   = 1'b0;
    unique case (1'b1)
      one[0]: st_n = READY;
      one[1]: begin
        q_n  = q_new;
        load = 1'b1;
      end
      one[2]: if (st_q != READY) begin
        q_n  = q_new;
        load = 1'b1;
      end
      one[3]: begin
        unique case (st_q)
          ARBITRATE: begin
            slot_n = slot_dec;
            if (slot_dec == '0) begin
              st_n  = REPLY;
              rep_n = 1'b1;
            end
          end
          REPLY, ACKNOWLEDGED: begin
            st_n   = ARBITRATE;
            slot_n = SLOT_W'(SLOT_WRAP);
          end
          default: ;
        endcase
      end
      one[4]: if (st_q == REPLY || st_q == ACKNOWLEDGED) begin
        if (bus.ack_rn == rn_q) begin
          st_n  = ACKNOWLEDGED;
          epc_n = 1'b1;
        end else begin
          st_n = ARBITRATE;
        end
      end
      one[5]: if (st_q != READY) st_n = ARBITRATE;
      default: ;
    endcase
    if (load) begin
      slot_n = slot_ld;
      rn_n   = bus.rns;
      if (slot_ld == '0) begin
        st_n  = REPLY;
        rep_n = 1'b1;
      end else begin
        st_n = ARBITRATE;
      end
    end
  end

  always_ff @(posedge clk_1_92m) begin
    if (!rst_n) begin
      st_q   <= READY;
      q_q    <= '0;
      slot_q <= '0;
      rn_q   <= '0;
      rep_q  <= 1'b0;
      epc_q  <= 1'b0;
    end else begin
      st_q   <= st_n;
      q_q    <= q_n;
      slot_q <= slot_n;
      rn_q   <= rn_n;
      rep_q  <= rep_n;
      epc_q  <= epc_n;
    end
  end

  assign bus.state     = st_q;
  assign bus.q_cur     = q_q;
  assign bus.slot_cnt  = slot_q;
  assign bus.rn16      = rn_q;
  assign bus.reply_req = rep_q;
  assign bus.epc_req   = epc_q;

endmodule

// File: tb/tb_gen2_slot_ctrl.sv
// Testbench for gen2_slot_ctrl: directed scenarios plus randomized
// command streams against a behavioural model of the slot rules.
module tb_gen2_slot_ctrl;

  typedef struct {
    bit        sel;
    bit        qry;
    bit [3:0]  qq;
    bit        adj;
    bit [1:0]  ud;
    bit        rep;
    bit        ack;
    bit [15:0] arn;
    bit        nak;
    bit [15:0] rns;
    bit        rst_n;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_st, m_q, m_slot, m_rn;
  bit m_rep, m_epc;

  always #5 clk = ~clk;

  gen2_slot_ctrl_if #(.Q_W(4), .SLOT_W(15)) bus ();

  gen2_slot_ctrl #(
    .Q_W   (4),
    .SLOT_W(15)
  ) dut (
    .clk_1_92m(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  function automatic cmd_t idle();
    cmd_t c;
    c.sel = 0; c.qry = 0; c.qq = 0; c.adj = 0; c.ud = 0;
    c.rep = 0; c.ack = 0; c.arn = 0; c.nak = 0;
    c.rns = 16'($urandom); c.rst_n = 1;
    return c;
  endfunction

  function automatic logic [38:0] pk(int st, int q, int slot,
                                     int rn, bit rp, bit ep);
    return {2'(st), 4'(q), 15'(slot), 16'(rn), rp, ep};
  endfunction

  function automatic logic [38:0] obs();
    return {bus.state, bus.q_cur, bus.slot_cnt, bus.rn16,
            bus.reply_req, bus.epc_req};
  endfunction

  // Reference: slot window is rns modulo 2^Q; states as plain integers.
  function automatic void mload(bit [15:0] r);
    m_slot = int'(r) % (1 << m_q);
    m_rn   = int'(r);
    if (m_slot == 0) begin
      m_st  = 2;
      m_rep = 1;
    end else begin
      m_st = 1;
    end
  endfunction

  function automatic void mstep(cmd_t c);
    m_rep = 0;
    m_epc = 0;
    if (!c.rst_n) begin
      m_st = 0; m_q = 0; m_slot = 0; m_rn = 0;
    end else if (c.sel) begin
      m_st = 0;
    end else if (c.qry) begin
      m_q = c.qq;
      mload(c.rns);
    end else if (c.adj) begin
      if (m_st != 0) begin
        if (c.ud == 2'b11 && m_q < 15) m_q = m_q + 1;
        else if (c.ud == 2'b01 && m_q > 0) m_q = m_q - 1;
        mload(c.rns);
      end
    end else if (c.rep) begin
      if (m_st == 1) begin
        m_slot = (m_slot + 32767) % 32768;
        if (m_slot == 0) begin
          m_st  = 2;
          m_rep = 1;
        end
      end else if (m_st >= 2) begin
        m_st   = 1;
        m_slot = 32767;
      end
    end else if (c.ack) begin
      if (m_st >= 2) begin
        if (int'(c.arn) == m_rn) begin
          m_st  = 3;
          m_epc = 1;
        end else begin
          m_st = 1;
        end
      end
    end else if (c.nak) begin
      if (m_st != 0) m_st = 1;
    end
  endfunction

  task automatic drive_idle();
    bus.cmd_select    = 0;
    bus.cmd_query     = 0;
    bus.query_q       = 4'($urandom);
    bus.cmd_query_adj = 0;
    bus.updn          = 2'($urandom);
    bus.cmd_query_rep = 0;
    bus.cmd_ack       = 0;
    bus.ack_rn        = 16'($urandom);
    bus.cmd_nak       = 0;
    bus.rns           = 16'($urandom);
    rst_n             = 1;
  endtask

  // One clock: drive on negedge, model steps, outputs settle #1 after posedge.
  task automatic apply(input cmd_t c);
    @(negedge clk);
    bus.cmd_select    = c.sel;
    bus.cmd_query     = c.qry;
    bus.query_q       = c.qq;
    bus.cmd_query_adj = c.adj;
    bus.updn          = c.ud;
    bus.cmd_query_rep = c.rep;
    bus.cmd_ack       = c.ack;
    bus.ack_rn        = c.arn;
    bus.cmd_nak       = c.nak;
    bus.rns           = c.rns;
    rst_n             = c.rst_n;
    mstep(c);
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic test_reset();
    cmd_t c;
    logic [38:0] want;
    c = idle();
    c.rst_n = 0;
    apply(c);
    want = pk(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL reset got=%h want=%h", obs(), want);
    end
  endtask

  task automatic test_query_count();
    cmd_t c;
    logic [38:0] want;
    c = idle();
    c.qry = 1; c.qq = 4; c.rns = 16'h3014;
    apply(c);
    want = pk(1, 4, 4, 'h3014, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL query_q4 got=%h want=%h", obs(), want);
    end
    for (int i = 3; i >= 0; i--) begin
      c = idle();
      c.rep = 1;
      apply(c);
      want = (i == 0) ? pk(2, 4, 0, 'h3014, 1, 0)
                      : pk(1, 4, i, 'h3014, 0, 0);
      n_cmp++;
      if (obs() !== want) begin
        n_bad++;
        $display("FAIL query_rep_%0d got=%h want=%h", i, obs(), want);
      end
    end
    apply(idle());
    want = pk(2, 4, 0, 'h3014, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL reply_pulse_once got=%h want=%h", obs(), want);
    end
  endtask

  task automatic test_q0();
    cmd_t c;
    logic [38:0] want;
    c = idle();
    c.qry = 1; c.qq = 0; c.rns = 16'hBEEF;
    apply(c);
    want = pk(2, 0, 0, 'hBEEF, 1, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL query_q0 got=%h want=%h", obs(), want);
    end
  endtask

  task automatic test_ack();
    cmd_t c;
    logic [38:0] want;
    c = idle();
    c.ack = 1; c.arn = 16'hBEEF;
    apply(c);
    want = pk(3, 0, 0, 'hBEEF, 0, 1);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL ack_match got=%h want=%h", obs(), want);
    end
    c = idle();
    c.qry = 1; c.qq = 0; c.rns = 16'h1234;
    apply(c);
    c = idle();
    c.ack = 1; c.arn = 16'h1235;
    apply(c);
    want = pk(1, 0, 0, 'h1234, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL ack_mismatch got=%h want=%h", obs(), want);
    end
  endtask

  task automatic test_adjust_sat();
    cmd_t c;
    logic [38:0] want;
    c = idle();
    c.qry = 1; c.qq = 15; c.rns = 16'h8001;
    apply(c);
    want = pk(1, 15, 1, 'h8001, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL query_q15 got=%h want=%h", obs(), want);
    end
    c = idle();
    c.adj = 1; c.ud = 2'b11; c.rns = 16'h0000;
    apply(c);
    want = pk(2, 15, 0, 'h0000, 1, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL adj_up_sat got=%h want=%h", obs(), want);
    end
    c = idle();
    c.qry = 1; c.qq = 0; c.rns = 16'h5555;
    apply(c);
    c = idle();
    c.adj = 1; c.ud = 2'b01; c.rns = 16'hFFFF;
    apply(c);
    want = pk(2, 0, 0, 'hFFFF, 1, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL adj_dn_sat got=%h want=%h", obs(), want);
    end
    c = idle();
    c.sel = 1;
    apply(c);
    c = idle();
    c.adj = 1; c.ud = 2'b11; c.rns = 16'h0007;
    apply(c);
    want = pk(0, 0, 0, 'hFFFF, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL adj_in_ready got=%h want=%h", obs(), want);
    end
  endtask

  task automatic test_rep_wrap_nak();
    cmd_t c;
    logic [38:0] want;
    c = idle();
    c.qry = 1; c.qq = 0; c.rns = 16'hA5A5;
    apply(c);
    c = idle();
    c.ack = 1; c.arn = 16'hA5A5;
    apply(c);
    c = idle();
    c.rep = 1;
    apply(c);
    want = pk(1, 0, 'h7FFF, 'hA5A5, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL rep_wrap got=%h want=%h", obs(), want);
    end
    c = idle();
    c.qry = 1; c.qq = 0; c.rns = 16'h0F0F;
    apply(c);
    c = idle();
    c.nak = 1;
    apply(c);
    want = pk(1, 0, 0, 'h0F0F, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL nak_reply got=%h want=%h", obs(), want);
    end
  endtask

  task automatic test_select_prio();
    cmd_t c;
    logic [38:0] want;
    c = idle();
    c.sel = 1; c.qry = 1; c.qq = 0; c.rns = 16'h2222;
    apply(c);
    want = pk(0, 0, 0, 'h0F0F, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL select_prio got=%h want=%h", obs(), want);
    end
  endtask

  task automatic test_reset_mid();
    cmd_t c;
    logic [38:0] want;
    c = idle();
    c.qry = 1; c.qq = 3; c.rns = 16'h0008;
    apply(c);
    want = pk(2, 3, 0, 'h0008, 1, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL query_q3 got=%h want=%h", obs(), want);
    end
    c = idle();
    c.rst_n = 0; c.qry = 1; c.qq = 5; c.rns = 16'h0001;
    apply(c);
    want = pk(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (obs() !== want) begin
      n_bad++;
      $display("FAIL reset_mid got=%h want=%h", obs(), want);
    end
  endtask

  task automatic test_random();
    cmd_t c;
    logic [38:0] want;
    for (int i = 0; i < 800; i++) begin
      c = idle();
      c.sel = ($urandom_range(0, 15) == 0);
      c.qry = ($urandom_range(0, 5) == 0);
      c.qq  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                          : 4'($urandom_range(0, 3));
      c.adj = ($urandom_range(0, 5) == 0);
      c.ud  = 2'($urandom);
      c.rep = ($urandom_range(0, 2) == 0);
      c.ack = ($urandom_range(0, 4) == 0);
      c.arn = ($urandom_range(0, 1) == 1) ? 16'(m_rn) : 16'($urandom);
      c.nak = ($urandom_range(0, 9) == 0);
      c.rst_n = ($urandom_range(0, 79) != 0);
      apply(c);
      want = pk(m_st, m_q, m_slot, m_rn, m_rep, m_epc);
      n_cmp++;
      if (obs() !== want) begin
        n_bad++;
        $display("FAIL random_%0d got=%h want=%h", i, obs(), want);
      end
      n_cmp++;
      if ((bus.reply_req & bus.epc_req) !== 1'b0) begin
        n_bad++;
        $display("FAIL excl_req_%0d got=%b%b want=not both",
                 i, bus.reply_req, bus.epc_req);
      end
    end
  endtask

  initial begin
    m_st = 0; m_q = 0; m_slot = 0; m_rn = 0; m_rep = 0; m_epc = 0;
    drive_idle();
    rst_n = 0;
    test_reset();
    test_query_count();
    test_q0();
    test_ack();
    test_adjust_sat();
    test_rep_wrap_nak();
    test_select_prio();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gen2_slot_ctrl.md
# gen2_slot_ctrl

Inventory slot controller for the 6C (EPC Gen2) tag digital core, directly downstream of the RN16 shift generator. On each Query/QueryAdjust it samples the generator's 16-bit random word, loads the slot counter with the low Q bits and latches the full word as the reply RN16. It decrements the slot on QueryRep, requests RN16 backscatter when the slot reaches zero, and checks the ACK handle. Command pulses come from the command decoder; `reply_req` and `epc_req` go to the backscatter encoder.

## Interface
- `Q_W`, 4: width of the Q parameter (Q range 0..15).
- `SLOT_W`, 15: slot counter width.
- `clk_1_92m`  in  1  core clock, 1.92 MHz.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `rns`  in  16  random word from the RN16 generator, sampled on command cycles.
- `cmd_select`  in  1  Select decoded pulse (1 cycle).
- `cmd_query`  in  1  Query decoded pulse.
- `query_q`  in  Q_W  Q field of Query, valid with `cmd_query`.
- `cmd_query_adj`  in  1  QueryAdjust pulse.
- `updn`  in  2  QueryAdjust UpDn field: 2'b11 = Q+1, 2'b01 = Q−1, 2'b00 = unchanged, 2'b10 = treated as unchanged.
- `cmd_query_rep`  in  1  QueryRep pulse.
- `cmd_ack`  in  1  ACK pulse.
- `ack_rn`  in  16  RN16 field of ACK, valid with `cmd_ack`.
- `cmd_nak`  in  1  NAK pulse.
- `state`  out  2  current state encoding.
- `q_cur`  out  Q_W  current Q.
- `slot_cnt`  out  SLOT_W  slot counter.
- `rn16`  out  16  latched reply handle.
- `reply_req`  out  1  1-cycle pulse requesting RN16 backscatter.
- `epc_req`  out  1  1-cycle pulse requesting PC/EPC backscatter.

## Operation
- States: READY (2'd0), ARBITRATE (2'd1), REPLY (2'd2), ACKNOWLEDGED (2'd3).
- Command priority within a single cycle is select > query > query_adj > query_rep > ack > nak. Only the highest-priority pulse is acted on; the others are dropped.
- Slot load (any state on `cmd_query`, and on `cmd_query_adj` outside READY):
  - `slot_cnt <= rns & ((1<<Q)−1)`, using the new Q.
  - `rn16 <= rns`.
  - If the loaded value is 0: go to REPLY and pulse `reply_req`. Otherwise go to ARBITRATE.
- Query: `q_cur <= query_q`, then slot load.
- QueryAdjust:
  - `q_cur` is updated per `updn`, saturating at 0 and 15.
  - Then slot load.
  - Ignored in READY.
- QueryRep:
  - ARBITRATE: `slot_cnt − 1`. If the result is 0: go to REPLY, pulse `reply_req`, and leave `rn16` unchanged.
  - REPLY or ACKNOWLEDGED: go to ARBITRATE with `slot_cnt <= 15'h7FFF`, modelling the 0 → 7FFF wrap.
  - READY: ignored.
- ACK:
  - REPLY or ACKNOWLEDGED with `ack_rn == rn16`: go to ACKNOWLEDGED and pulse `epc_req`.
  - Mismatch: go to ARBITRATE; slot unchanged.
  - Ignored in READY and ARBITRATE.
- NAK: any state except READY goes to ARBITRATE; slot unchanged.
- Select: any state goes to READY; `q_cur`, `slot_cnt` and `rn16` are held.

## Timing
- All outputs are registered. The response appears on the clock edge following the command pulse, i.e. 1-cycle latency.
- `reply_req` and `epc_req` are high for exactly one cycle per triggering command and are never asserted together.
- `rns` is sampled only on the same cycle as the command pulse. Its value on any other cycle has no effect.
- Reset (`rst_n` low at a clock edge, including mid-operation) sets:
  - `state`: READY
  - `q_cur`: 4'd0
  - `slot_cnt`: 15'd0
  - `rn16`: 16'h0000
  - `reply_req`, `epc_req`: 0
- Command pulses during reset are lost.
- Q = 0 always loads slot 0, giving an immediate REPLY.

## Structure
- The shared package `rfid6c_pkg` holds:
  - the state enum (READY, ARBITRATE, REPLY, ACKNOWLEDGED),
  - the `updn` code constants,
  - `Q_MAX` = 15,
  - `SLOT_WRAP` = 15'h7FFF.
- Sub-module `gen2_slot_mask`: combinational Q → `(1<<Q)−1` mask plus the saturating Q up/down. It is reused by the ISO/TID-handling cores.

## Test plan
- Reset, then Query with Q=4 and `rns`=16'h3014 → `slot_cnt`=4, `rn16`=16'h3014, ARBITRATE. Four QueryReps → REPLY with one `reply_req` pulse on the fourth.
- Query with Q=0 and `rns`=16'hBEEF → REPLY next cycle, `reply_req` pulse, `rn16`=16'hBEEF.
- In REPLY: ACK with `ack_rn`=`rn16` → ACKNOWLEDGED and `epc_req` pulse. ACK with `ack_rn`=`rn16`^1 from REPLY → ARBITRATE, no `epc_req`.
- Q=15 then QueryAdjust with `updn`=11 → Q stays 15. Q=0 then QueryAdjust with `updn`=01 → Q stays 0 and REPLY is entered.
- In ACKNOWLEDGED: QueryRep → ARBITRATE with `slot_cnt`=7FFF. NAK in REPLY → ARBITRATE.
- `cmd_select` and `cmd_query` in the same cycle → READY, no `reply_req`. Assert `rst_n` low while in REPLY → all outputs take their reset values on the next edge.
